alu_counter_memory: RTL and testbench

ALU_COUNTER_MEMORY -- requirements
Module: alu_counter_memory

---
 rtl/alu_counter_memory.sv | 164 ++++++++++++++++
 tb/tb_alu_counter_memory.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_counter_memory.sv
// Three-phase sequencer with a registered 64-bit ALU and a unified byte-addressed memory.
// The ALU, data-read and fetch registers update once every 3 clocks, on the edge where t3 is high.
// There is no backpressure: reads and writes happen on every t3 edge, so fetch never stalls.
module alu_counter_memory #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] aluA,
  input  logic [63:0] aluB,
  input  logic [3:0]  alufun,
  output logic [63:0] e_valE,
  output logic        cf,
  output logic        zf,
  output logic        sf,
  output logic        of,
  input  logic [63:0] mem_addr,
  input  logic [63:0] f_pc,
  input  logic [63:0] mem_wdata,
  input  logic        mem_write,
  output logic [63:0] m_valM,
  output logic [79:0] mem_out,
  output logic        t1,
  output logic        t2,
  output logic        t3
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  localparam logic [1:0] PH_T1 = 2'd0;
  localparam logic [1:0] PH_T2 = 2'd1;
  localparam logic [1:0] PH_T3 = 2'd2;

  logic [1:0]  phase_q, phase_d;
  logic [63:0] e_vale_q, e_vale_d;
  logic        cf_q, cf_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic [63:0] m_valm_q, m_valm_d;
  logic [79:0] mem_out_q, mem_out_d;

  logic [7:0]  mem_q [0:MEM_BYTES-1];

  logic        t3_now;
  logic [64:0] sum65;
  logic [63:0] alu_res;
  logic        alu_cf, alu_of;
  logic [63:0] rd_valm;
  logic [79:0] rd_fetch;

  // Byte index of base+off; every byte of a multi-byte access wraps independently.
  function automatic logic [AW-1:0] byte_idx(input logic [63:0] base, input logic [3:0] off);
    logic [63:0] a;
    a = base + {60'd0, off};
    return AW'(a % 64'(MEM_BYTES));
  endfunction

  assign t3_now = (phase_q == PH_T3);
  assign t1     = (phase_q == PH_T1);
  assign t2     = (phase_q == PH_T2);
  assign t3     = t3_now;

  assign e_valE  = e_vale_q;
  assign cf      = cf_q;
  assign zf      = zf_q;
  assign sf      = sf_q;
  assign of      = of_q;
  assign m_valM  = m_valm_q;
  assign mem_out = mem_out_q;

  // Phase sequencer: 0,1,2,0,... (the unused code 3 falls back to 0).
  always_comb begin
    phase_d = (phase_q == PH_T3) ? PH_T1 : phase_q + 2'd1;
  end

  // ALU result and flags; subtract is B-A, and unknown codes behave as add.
  always_comb begin
    sum65   = {1'b0, aluA} + {1'b0, aluB};
    alu_res = sum65[63:0];
    alu_cf  = sum65[64];
    alu_of  = (aluA[63] == aluB[63]) && (alu_res[63] != aluA[63]);
    case (alufun)
      4'd2: begin
        alu_res = aluB - aluA;
        alu_cf  = (aluB < aluA);
        alu_of  = (aluA[63] != aluB[63]) && (alu_res[63] != aluB[63]);
      end
      4'd3: begin
        alu_res = aluA & aluB;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
      end
      4'd4: begin
        alu_res = aluA ^ aluB;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
      end
      default: ;
    endcase
  end

  // Little-endian reads of the current array contents (old data when a store hits the same bytes).
  always_comb begin
    rd_valm  = '0;
    rd_fetch = '0;
    for (int i = 0; i < 8; i++) begin
      rd_valm[8*i +: 8] = mem_q[byte_idx(mem_addr, 4'(i))];
    end
    for (int i = 0; i < 10; i++) begin
      rd_fetch[8*i +: 8] = mem_q[byte_idx(f_pc, 4'(i))];
    end
  end

  // Output registers capture new values only in the t3 phase, otherwise hold.
  always_comb begin
    e_vale_d  = e_vale_q;
    cf_d      = cf_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    m_valm_d  = m_valm_q;
    mem_out_d = mem_out_q;
    if (t3_now) begin
      e_vale_d  = alu_res;
      cf_d      = alu_cf;
      zf_d      = (alu_res == 64'd0);
      sf_d      = alu_res[63];
      of_d      = alu_of;
      m_valm_d  = rd_valm;
      mem_out_d = rd_fetch;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= PH_T1;
      e_vale_q  <= '0;
      cf_q      <= 1'b0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      m_valm_q  <= '0;
      mem_out_q <= '0;
    end else begin
      phase_q   <= phase_d;
      e_vale_q  <= e_vale_d;
      cf_q      <= cf_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
      m_valm_q  <= m_valm_d;
      mem_out_q <= mem_out_d;
    end
  end

  // Store path: array is never cleared by reset, but reset blocks stores.
  always_ff @(posedge clk) begin
    if (rst_n && t3_now && mem_write) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[byte_idx(mem_addr, 4'(i))] <= mem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_alu_counter_memory.sv
// Randomized bench for alu_counter_memory against a cycle-count based reference model.
// Each clock the model advances, then every output is compared 1 time unit after the edge.
// Directed cases cover overflow, borrow, wraparound, read-before-write, hold and mid-run reset.
module tb_alu_counter_memory;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] aluA = '0, aluB = '0, mem_addr = '0, f_pc = '0, mem_wdata = '0;
  logic [3:0]  alufun = '0;
  logic        mem_write = 1'b0;
  logic [63:0] e_valE, m_valM;
  logic [79:0] mem_out;
  logic        cf, zf, sf, of, t1, t2, t3;

  alu_counter_memory #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n), .aluA(aluA), .aluB(aluB), .alufun(alufun),
    .e_valE(e_valE), .cf(cf), .zf(zf), .sf(sf), .of(of),
    .mem_addr(mem_addr), .f_pc(f_pc), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .m_valM(m_valM), .mem_out(mem_out), .t1(t1), .t2(t2), .t3(t3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: clocks since reset, expected outputs, byte memory with known flags.
  int          cnt = 0;
  logic [63:0] x_vale = '0, x_valm = '0;
  logic [79:0] x_out = '0;
  logic        x_cf = 0, x_zf = 0, x_sf = 0, x_of = 0;
  bit          x_vk = 1, x_ok = 1;
  logic [7:0]  mm [MB];
  bit          mk [MB];

  function automatic int midx(input logic [63:0] base, input int off);
    logic [63:0] a;
    a = base + 64'(off);
    return int'(a % 64'(MB));
  endfunction

  task automatic model_edge();
    logic [64:0] w;
    if (!rst_n) begin
      cnt = 0; x_vale = '0; x_valm = '0; x_out = '0;
      x_cf = 0; x_zf = 0; x_sf = 0; x_of = 0; x_vk = 1; x_ok = 1;
    end else begin
      if (cnt % 3 == 2) begin
        case (alufun)
          2: begin
            w = {aluB[63], aluB} - {aluA[63], aluA};
            x_vale = aluB - aluA; x_cf = (aluB < aluA); x_of = (w[64] != w[63]);
          end
          3: begin x_vale = aluA & aluB; x_cf = 0; x_of = 0; end
          4: begin x_vale = aluA ^ aluB; x_cf = 0; x_of = 0; end
          default: begin
            w = {aluA[63], aluA} + {aluB[63], aluB};
            x_vale = aluA + aluB; x_cf = (x_vale < aluA); x_of = (w[64] != w[63]);
          end
        endcase
        x_zf = (x_vale == 64'd0);
        x_sf = x_vale[63];
        x_vk = 1; x_ok = 1;
        for (int i = 0; i < 8; i++) begin
          x_valm[8*i +: 8] = mm[midx(mem_addr, i)];
          if (!mk[midx(mem_addr, i)]) x_vk = 0;
        end
        for (int i = 0; i < 10; i++) begin
          x_out[8*i +: 8] = mm[midx(f_pc, i)];
          if (!mk[midx(f_pc, i)]) x_ok = 0;
        end
        if (mem_write) begin
          for (int i = 0; i < 8; i++) begin
            mm[midx(mem_addr, i)] = mem_wdata[8*i +: 8];
            mk[midx(mem_addr, i)] = 1;
          end
        end
      end
      cnt++;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".t1"}, 80'(t1), 80'(cnt % 3 == 0));
    check_eq({tag, ".t2"}, 80'(t2), 80'(cnt % 3 == 1));
    check_eq({tag, ".t3"}, 80'(t3), 80'(cnt % 3 == 2));
    check_eq({tag, ".onehot"}, 80'($countones({t1, t2, t3})), 80'd1);
    check_eq({tag, ".e_valE"}, 80'(e_valE), 80'(x_vale));
    check_eq({tag, ".flags"}, 80'({cf, zf, sf, of}), 80'({x_cf, x_zf, x_sf, x_of}));
    if (x_vk) check_eq({tag, ".m_valM"}, 80'(m_valM), 80'(x_valm));
    if (x_ok) check_eq({tag, ".mem_out"}, mem_out, x_out);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] addr, input logic [63:0] pc,
                        input logic [63:0] wd, input logic wr);
    alufun = fun; aluA = a; aluB = b; mem_addr = addr; f_pc = pc; mem_wdata = wd; mem_write = wr;
  endtask

  // Hold one set of inputs over a full t1/t2/t3 group.
  task automatic op3(input string tag, input logic [3:0] fun, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] addr, input logic [63:0] pc,
                     input logic [63:0] wd, input logic wr);
    set_in(fun, a, b, addr, pc, wd, wr);
    repeat (3) tick(tag);
  endtask

  initial begin
    for (int i = 0; i < MB; i++) begin mm[i] = '0; mk[i] = 0; end

    // Reset state
    rst_n = 0;
    tick("reset");
    check_eq("reset_t1", 80'(t1), 80'd1);
    check_eq("reset_e_valE", 80'(e_valE), 80'd0);
    check_eq("reset_mem_out", mem_out, 80'd0);
    rst_n = 1;

    // Strobe sequence over 9 clocks
    repeat (9) tick("phase");

    // Fill memory so every later read has a defined value
    for (int k = 0; k < MB / 8; k++)
      op3("fill", 4'd3, 64'(k), 64'(k), 64'(8 * k), 64'd0, {$urandom, $urandom}, 1'b1);

    // Signed overflow on add
    op3("add_ovf", 4'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0, 1'b0);
    check_eq("add_ovf_val", 80'(e_valE), 80'(64'h8000_0000_0000_0000));
    check_eq("add_ovf_flags", 80'({cf, zf, sf, of}), 80'(4'b0011));

    // Subtract: equal operands, then borrow
    op3("sub_eq", 4'd2, 64'd5, 64'd5, 64'd0, 64'd0, 64'd0, 1'b0);
    check_eq("sub_eq_val", 80'(e_valE), 80'd0);
    check_eq("sub_eq_flags", 80'({cf, zf}), 80'(2'b01));
    op3("sub_brw", 4'd2, 64'd6, 64'd5, 64'd0, 64'd0, 64'd0, 1'b0);
    check_eq("sub_brw_val", 80'(e_valE), 80'(64'hFFFF_FFFF_FFFF_FFFF));
    check_eq("sub_brw_flags", 80'({cf, sf}), 80'(2'b11));

    // Inputs changed outside t3 must not reach the outputs until the t3 edge
    set_in(4'd3, 64'd1, 64'd1, 64'd0, 64'd0, 64'd0, 1'b0);
    tick("hold");
    check_eq("hold_t1_edge", 80'(e_valE), 80'(64'hFFFF_FFFF_FFFF_FFFF));
    aluA = 64'd3; aluB = 64'd7;
    tick("hold");
    check_eq("hold_t2_edge", 80'(e_valE), 80'(64'hFFFF_FFFF_FFFF_FFFF));
    tick("hold");
    check_eq("hold_t3_edge", 80'(e_valE), 80'd3);

    // Store then load, plus fetch of the same bytes
    op3("st10", 4'd1, 64'd0, 64'd0, 64'h10, 64'd0, 64'h1122_3344_5566_7788, 1'b1);
    op3("ld10", 4'd1, 64'd0, 64'd0, 64'h10, 64'h10, 64'd0, 1'b0);
    check_eq("ld10_val", 80'(m_valM), 80'(64'h1122_3344_5566_7788));
    check_eq("fetch10_b0", 80'(mem_out[7:0]), 80'h88);

    // Same-edge store and load returns previous data
    op3("rbw", 4'd1, 64'd0, 64'd0, 64'h10, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
    check_eq("rbw_old", 80'(m_valM), 80'(64'h1122_3344_5566_7788));
    op3("rbw2", 4'd1, 64'd0, 64'd0, 64'h10, 64'd0, 64'd0, 1'b0);
    check_eq("rbw_new", 80'(m_valM), 80'(64'hDEAD_BEEF_0BAD_F00D));

    // Store straddling the top of memory wraps to byte 0
    op3("wrap_st", 4'd1, 64'd0, 64'd0, 64'(MB - 4), 64'd0, 64'hAABB_CCDD_EEFF_0011, 1'b1);
    op3("wrap_ld", 4'd1, 64'd0, 64'd0, 64'd0, 64'(MB - 2), 64'd0, 1'b0);
    check_eq("wrap_lo32", 80'(m_valM[31:0]), 80'(32'hAABB_CCDD));
    check_eq("wrap_b0", 80'(m_valM[7:0]), 80'hDD);
    check_eq("wrap_fetch", 80'(mem_out[31:0]), 80'(32'hCCDD_EEFF));

    // Mid-run reset: outputs clear, memory survives, store on that edge is dropped
    set_in(4'd1, 64'd9, 64'd9, 64'd0, 64'd0, 64'h5555_5555_5555_5555, 1'b1);
    tick("mid");
    rst_n = 0;
    tick("mid_rst");
    tick("mid_rst");
    check_eq("mid_rst_e_valE", 80'(e_valE), 80'd0);
    check_eq("mid_rst_m_valM", 80'(m_valM), 80'd0);
    check_eq("mid_rst_t1", 80'(t1), 80'd1);
    rst_n = 1;
    op3("post_rst", 4'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    check_eq("post_rst_mem", 80'(m_valM[31:0]), 80'(32'hAABB_CCDD));

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      alufun    = 4'($urandom_range(0, 15));
      aluA      = {$urandom, $urandom};
      aluB      = ($urandom_range(0, 3) == 0) ? aluA : {$urandom, $urandom};
      mem_addr  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, MB + 15)) : {$urandom, $urandom};
      f_pc      = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, MB + 15)) : {$urandom, $urandom};
      mem_wdata = {$urandom, $urandom};
      mem_write = 1'($urandom_range(0, 1));
      rst_n     = ($urandom_range(0, 99) >= 3);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
